// File: rtl/led_pkg.sv
// Shared constants, channel state encoding and the gamma duty map for the LED fade driver.
package led_pkg;

    localparam int NUM_LED = 8;
    localparam int LEVEL_W = 8;
    localparam logic [LEVEL_W-1:0] PWM_MAX = 8'd254;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RISE = 2'd1,
        HOLD = 2'd2,
        FALL = 2'd3
    } chan_state_t;

    // Squared map keeps full scale pinned so level 255 stays always-on.
    function automatic logic [LEVEL_W-1:0] gamma_map(input logic [LEVEL_W-1:0] level);
        logic [2*LEVEL_W-1:0] sq;
        sq = {{LEVEL_W{1'b0}}, level} * {{LEVEL_W{1'b0}}, level};
        return (level == {LEVEL_W{1'b1}}) ? {LEVEL_W{1'b1}} : sq[2*LEVEL_W-1:LEVEL_W];
    endfunction

endpackage

// File: rtl/led_fade_chan.sv
// One fade channel: level register, ramp FSM, duty map and PWM compare.
// Duty is gamma-mapped when LED_GAMMA_EN is defined, linear otherwise.
//   state | meaning
//   OFF   | level 0, target 0
//   RISE  | ramping up toward target
//   HOLD  | level equals a nonzero target
//   FALL  | ramping down toward target
module led_fade_chan
    import led_pkg::*;
#(
    parameter int FADE_STEP = 8
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               enable,
    input  logic               tick,
    input  logic [LEVEL_W-1:0] tgt,
    input  logic [LEVEL_W-1:0] pwm_cnt,
    output logic [LEVEL_W-1:0] level,
    output logic               on
);

    localparam logic [LEVEL_W:0] STEP = (LEVEL_W+1)'(FADE_STEP);

    chan_state_t        state, state_nxt;
    logic [LEVEL_W:0]   up_sum, dn_diff;
    logic [LEVEL_W-1:0] level_nxt, duty;

    // 9-bit ramp: carry or borrow in the top bit clamps to the target.
    always_comb begin
        up_sum    = {1'b0, level} + STEP;
        dn_diff   = {1'b0, level} - STEP;
        level_nxt = level;
        if (tgt > level)
            level_nxt = (up_sum > {1'b0, tgt}) ? tgt : up_sum[LEVEL_W-1:0];
        else if (tgt < level)
            level_nxt = (dn_diff[LEVEL_W] || (dn_diff[LEVEL_W-1:0] < tgt)) ? tgt
                                                                           : dn_diff[LEVEL_W-1:0];
    end

    always_comb begin
        state_nxt = state;
        if (tick) begin
            case (state)
                OFF: begin
                    if (tgt != '0) state_nxt = RISE;
                end
                RISE: begin
                    if (tgt < level)           state_nxt = FALL;
                    else if (level_nxt == tgt) state_nxt = HOLD;
                end
                HOLD: begin
                    if (tgt > level)      state_nxt = RISE;
                    else if (tgt < level) state_nxt = FALL;
                end
                FALL: begin
                    if (tgt > level)           state_nxt = RISE;
                    else if (level_nxt == tgt) state_nxt = (tgt == '0) ? OFF : HOLD;
                end
                default: state_nxt = OFF;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn || !enable) begin
            level <= '0;
            state <= OFF;
        end else if (tick) begin
            level <= level_nxt;
            state <= state_nxt;
        end
    end

`ifdef LED_GAMMA_EN
    assign duty = gamma_map(level);
`else
    assign duty = level;
`endif

    assign on = (duty > pwm_cnt);

endmodule

// File: rtl/led_fade_driver.sv
// LED fade driver: per-channel brightness ramps modulated onto a shared 255-step PWM carrier.
// Define LED_GAMMA_EN to map channel levels to duty through a squared (perceptual) curve.
module led_fade_driver
    import led_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int FADE_DIV   = 50000,
    parameter int FADE_STEP  = 8,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               enable,
    input  logic [NUM_LED-1:0] led_in,
    input  logic [LEVEL_W-1:0] max_level,
    output logic [NUM_LED-1:0] led_out,
    output logic               busy
);

    localparam logic [15:0]        PRESC_LAST = 16'(CLK_DIV - 1);
    localparam logic [23:0]        FADE_LAST  = 24'(FADE_DIV - 1);
    localparam logic [NUM_LED-1:0] OFF_PINS   = {NUM_LED{ACTIVE_LOW}};

    logic [NUM_LED-1:0] led_in_q, on, differs;
    logic [15:0]        presc;
    logic [LEVEL_W-1:0] pwm_cnt;
    logic [23:0]        fade_cnt;
    logic               en_q, presc_wrap, tick;

    assign presc_wrap = (presc == PRESC_LAST);
    assign tick       = (fade_cnt == FADE_LAST);

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            led_in_q <= '0;
            en_q     <= 1'b0;
            presc    <= '0;
            pwm_cnt  <= '0;
            fade_cnt <= '0;
            led_out  <= OFF_PINS;
        end else begin
            led_in_q <= led_in;
            en_q     <= enable;
            if (!enable) begin
                presc    <= '0;
                pwm_cnt  <= '0;
                fade_cnt <= '0;
                led_out  <= OFF_PINS;
            end else begin
                presc <= presc_wrap ? '0 : presc + 16'd1;
                if (presc_wrap)
                    pwm_cnt <= (pwm_cnt == PWM_MAX) ? '0 : pwm_cnt + 8'd1;
                fade_cnt <= tick ? '0 : fade_cnt + 24'd1;
                led_out  <= on ^ OFF_PINS;
            end
        end
    end

    for (genvar i = 0; i < NUM_LED; i++) begin : gen_chan
        logic [LEVEL_W-1:0] tgt;
        logic [LEVEL_W-1:0] level;

        assign tgt = led_in_q[i] ? max_level : '0;

        led_fade_chan #(
            .FADE_STEP(FADE_STEP)
        ) u_chan (
            .HCLK    (HCLK),
            .HRESETn (HRESETn),
            .enable  (enable),
            .tick    (tick),
            .tgt     (tgt),
            .pwm_cnt (pwm_cnt),
            .level   (level),
            .on      (on[i])
        );

        assign differs[i] = (level != tgt);
    end

    // en_q masks the stale targets during the cycle after the driver is disabled.
    assign busy = en_q & (|differs);

endmodule

// File: doc/led_fade_driver.md
Name: led_fade_driver

Overview:
- Downstream stage of the AHB-Lite LED peripheral.
- Consumes its 8-bit on/off LED pattern and drives the physical LED pins.
- Each channel fades smoothly between off and a programmable brightness, using a per-channel level ramp and a shared PWM carrier.
- Replaces direct pin assignment of the peripheral's LED bus at the top level.

Parameters:
- CLK_DIV, 4: HCLK cycles per PWM counter step; legal range 1..65535.
- FADE_DIV, 50000: HCLK cycles per fade tick; legal range 1..2^24-1.
- FADE_STEP, 8: level change per fade tick; legal range 1..255.
- ACTIVE_LOW, 0: 1 inverts led_out so that off = 1.

Ports:
- HCLK, input, 1: system clock.
- HRESETn, input, 1: reset; synchronous, active-low.
- enable, input, 1: driver enable.
- led_in, input, 8: on/off pattern from the LED peripheral; bit i on = channel i target is max_level.
- max_level, input, 8: brightness ceiling shared by all channels.
- led_out, output, 8: PWM-modulated pin drive, registered.
- busy, output, 1: high while any channel level differs from its target.

Behaviour:
- Reset (HRESETn low at a HCLK edge):
  - levels, prescaler, pwm_cnt, fade counter and led_in_q all go to 0.
  - All channel FSMs go to OFF.
  - led_out = 8'h00, or 8'hFF if ACTIVE_LOW; busy = 0.
  - Reset asserted mid-fade aborts immediately; no ramp-down.
- Input register: led_in_q <= led_in every cycle. Channel targets use led_in_q, so led_in reaches the targets with 1 cycle latency.
- Target per channel: tgt[i] = led_in_q[i] ? max_level : 0.
- Prescaler and PWM carrier:
  - Prescaler counts 0..CLK_DIV-1. On wrap, pwm_cnt advances 0..254 and then wraps to 0 (255-step period).
- Compare and output:
  - on[i] = duty[i] > pwm_cnt.
  - duty 0 = never on; duty 255 = always on.
  - led_out[i] <= on[i] XOR ACTIVE_LOW, so compare-to-pin latency is 1 cycle.
- Fade tick:
  - Fade counter counts 0..FADE_DIV-1; tick is asserted for one cycle at wrap.
  - Level arithmetic is 9-bit with saturation.
  - Rise: level = min(level + FADE_STEP, tgt).
  - Fall: level = max(level - FADE_STEP, tgt). Never underflows; never overshoots the target.
- Per-channel FSM (evaluated on tick only; levels are static between ticks):
  - OFF (level 0): tgt > 0 -> RISE.
  - RISE: level reaches tgt -> HOLD; tgt < level -> FALL.
  - HOLD (level == tgt > 0): tgt > level -> RISE; tgt < level -> FALL (this also covers tgt = 0).
  - FALL: level reaches tgt -> OFF if tgt = 0, else HOLD; tgt > level -> RISE.
- Pattern change mid-ramp: the channel reverses from its current level. No jump.
- max_level change: all HOLD/RISE channels re-target at the next tick.
- busy = OR over channels of (level != tgt), combinational from registers.
- enable = 0:
  - Next cycle: all levels = 0, FSMs = OFF, counters held at 0, led_out = off state.
  - enable re-asserted: counters restart from 0 and channels fade up from 0.
- Simultaneous PWM wrap and fade tick: the compare uses the pre-tick level. The new level applies from the next cycle.

Optional Feature:
- Macro LED_GAMMA_EN.
- Defined: duty[i] = (level*level) >> 8, except level 255 gives duty 255, for perceptual linearity. This is a pure combinational map and adds no latency.
- Undefined: duty[i] = level[i].

Decomposition:
- Package led_pkg holds:
  - NUM_LED = 8, LEVEL_W = 8, PWM_MAX = 8'd254.
  - Channel state enum: OFF, RISE, HOLD, FALL.
  - A gamma function used when LED_GAMMA_EN is defined.
- Sub-module led_fade_chan: one channel's level register, FSM, saturating ramp, duty map and compare. Instantiated 8 times.
- Top level owns led_in_q, the prescaler, pwm_cnt, the fade counter, the busy OR and the output registers.

Test Plan (CLK_DIV=1, FADE_DIV=4, FADE_STEP=64, max_level=255 unless noted):
- Reset -> led_out = 00 and busy = 0. Hold HRESETn low for 3 cycles with led_in = FF -> levels stay 0.
- led_in 00 -> 01:
  - ch0 level after successive ticks is 64, 128, 192, 255; FSM goes RISE then HOLD.
  - busy falls at the cycle level = 255.
  - led_out[0] is high for all 255 PWM steps once at 255.
- led_in 01 -> 00 when ch0 level = 128 (mid-rise) -> next ticks give 64, 0; FSM goes FALL then OFF; no underflow.
- FADE_STEP=100, max_level=150, led_in = 80 -> ch7 levels 100, 150 (clamped, no overshoot); led_out[7] duty is 150/255 of the PWM period.
- enable dropped while led_in = FF at HOLD -> 1 cycle later led_out = 00 and busy = 0. ACTIVE_LOW=1 variant -> led_out = FF.
- LED_GAMMA_EN defined, level = 128 -> duty 64 (64 of 255 PWM steps high); level = 255 -> always on.
